// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Memory direction codes, ECALL opcode, state encoding, FIFO entry.
package fetch_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] OPC_ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two instruction buffer between fetch and decode.
// Flush wins over push/pop; pop on empty and push on full are dropped.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clock) begin
        if (!reset && !i_flush && w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, state machine and mainmem initiator.
// Streams {pc, word} to decode through fetch_fifo.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_word,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic         r_halted;
    logic         r_fault;

    fetch_entry_t w_head;
    fetch_entry_t w_entry;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    logic         w_redirect;
    logic         w_rd_legal;
    logic         w_ecall;
    logic         w_at_end;

    assign w_pop      = inst_valid && inst_ready;
    assign w_redirect = redirect_valid && (r_state != FAULT);
    assign w_push     = (r_state == FETCH) && !w_redirect && (!w_full || w_pop);
    assign w_ecall    = (mem_data_out == OPC_ECALL);
    assign w_at_end   = (r_pc == LAST_ADDR);
    assign w_rd_legal = (redirect_pc[1:0] == 2'b00)
                     && (redirect_pc >= STARTING_ADDR)
                     && (redirect_pc <= LAST_ADDR);
    assign w_entry    = '{pc: r_pc, word: mem_data_out};

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect)
            w_state_nxt = w_rd_legal ? FETCH : FAULT;
        else if (w_push && w_ecall)
            w_state_nxt = HALT;
        else if (w_push && w_at_end)
            w_state_nxt = FAULT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= STARTING_ADDR;
            r_state  <= FETCH;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == HALT);
            r_fault  <= (w_state_nxt == FAULT);
            // PC holds on ECALL or at the top of memory so the range check never wraps.
            if (w_redirect)
                r_pc <= redirect_pc;
            else if (w_push && !w_ecall && !w_at_end)
                r_pc <= r_pc + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign mem_address    = r_pc;
    assign mem_data_in    = '0;
    assign mem_read_write = READ;
    assign inst_valid     = !w_empty;
    assign inst_pc        = w_head.pc;
    assign inst_word      = w_head.word;
    assign halted         = r_halted;
    assign fault          = r_fault;

endmodule
